// File: rtl/irq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | irq_pkg                                                              |
// | Register offsets, mode encodings and limits for the irq controller.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package irq_pkg;

  localparam int IRQ_MAX_SRCS = 15;

  localparam logic [1:0] IRQ_PENDING = 2'd0;
  localparam logic [1:0] IRQ_ENABLE  = 2'd1;
  localparam logic [1:0] IRQ_MODE    = 2'd2;
  localparam logic [1:0] IRQ_FORCE   = 2'd3;

  localparam logic IRQ_LEVEL = 1'b0;
  localparam logic IRQ_EDGE  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/prio_enc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prio_enc                                                             |
// | Returns the index of the highest set request bit, 0 when none set.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module prio_enc #(
  parameter int W = 4
) (
  input  logic [(1<<W)-1:0] req,
  output logic [W-1:0]      idx
);

  // Ascending scan so the highest set bit is the last one to write idx.
  always_comb begin
    idx = '0;
    for (int i = 0; i < (1 << W); i++) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | irq_ctrl                                                             |
// | Pending/enable/mode interrupt controller with priority vector out.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int IRQS  = 15,
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic [IRQS-1:0]  src,
  input  logic             io_rd,
  input  logic             io_wr,
  input  logic [1:0]       io_addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] io_dout,
  output logic             irq,
  output logic [3:0]       ivec,
  input  logic             iack
);

  logic [IRQS-1:0] r_pending;
  logic [IRQS-1:0] r_enable;
  logic [IRQS-1:0] r_mode;
  logic [IRQS-1:0] r_src_d;

  logic [IRQS-1:0] w_din;
  logic [IRQS-1:0] w_act;
  logic [IRQS-1:0] w_src_set;
  logic [IRQS-1:0] w_ack;
  logic [IRQS-1:0] w_force;
  logic [IRQS-1:0] w_w1c;
  logic [IRQS-1:0] w_set;
  logic [IRQS-1:0] w_clr;
  logic [15:0]     w_prio_in;
  logic [3:0]      w_ivec;
  logic            w_wr_pending;
  logic            w_wr_enable;
  logic            w_wr_mode;
  logic            w_wr_force;
  logic            w_unused_din;

  assign w_din        = din[IRQS-1:0];
  assign w_unused_din = ^din[WIDTH-1:IRQS];

  assign w_wr_pending = io_wr && (io_addr == IRQ_PENDING);
  assign w_wr_enable  = io_wr && (io_addr == IRQ_ENABLE);
  assign w_wr_mode    = io_wr && (io_addr == IRQ_MODE);
  assign w_wr_force   = io_wr && (io_addr == IRQ_FORCE);

  assign w_force = w_wr_force   ? w_din : '0;
  assign w_w1c   = w_wr_pending ? w_din : '0;

  // Per-source event detection and acknowledge decode.
  for (genvar i = 0; i < IRQS; i++) begin : g_src
    assign w_src_set[i] = (r_mode[i] == IRQ_EDGE) ? (src[i] & ~r_src_d[i]) : src[i];
    assign w_ack[i]     = iack && (w_ivec == 4'(i + 1));
  end

  // Sets are OR'd in after clears so a coincident set is never lost.
  assign w_set = w_src_set | w_force;
  assign w_clr = w_ack | w_w1c;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_pending <= '0;
      r_enable  <= '0;
      r_mode    <= '0;
      r_src_d   <= '0;
    end else begin
      r_src_d   <= src;
      r_pending <= (r_pending & ~w_clr) | w_set;
      if (w_wr_enable) r_enable <= w_din;
      if (w_wr_mode)   r_mode   <= w_din;
    end
  end

  assign w_act = r_pending & r_enable;

  // Bit 0 stays clear so the encoder output is already the 1-based vector.
  always_comb begin
    w_prio_in           = '0;
    w_prio_in[IRQS:1]   = w_act;
  end

  prio_enc #(
    .W (4)
  ) u_prio_enc (
    .req (w_prio_in),
    .idx (w_ivec)
  );

  assign ivec = w_ivec;
  assign irq  = (w_ivec != 4'd0);

  always_comb begin
    io_dout = '0;
    if (io_rd) begin
      case (io_addr)
        IRQ_PENDING: io_dout[IRQS-1:0] = r_pending;
        IRQ_ENABLE:  io_dout[IRQS-1:0] = r_enable;
        IRQ_MODE:    io_dout[IRQS-1:0] = r_mode;
        IRQ_FORCE:   io_dout[4:0]      = {irq, w_ivec};
        default:     io_dout           = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_irq_ctrl                                                          |
// | Scoreboard bench for irq_ctrl: expectations queued at stimulus time. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_irq_ctrl;

  localparam int IRQS  = 15;
  localparam int WIDTH = 18;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] val;
  } sb_entry_t;

  logic             clk;
  logic             arstn;
  logic [IRQS-1:0]  src;
  logic             io_rd;
  logic             io_wr;
  logic [1:0]       io_addr;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] io_dout;
  logic             irq;
  logic [3:0]       ivec;
  logic             iack;

  sb_entry_t sb[$];
  int n_cmp;
  int n_err;

  irq_ctrl #(
    .IRQS  (IRQS),
    .WIDTH (WIDTH)
  ) dut (
    .clk     (clk),
    .arstn   (arstn),
    .src     (src),
    .io_rd   (io_rd),
    .io_wr   (io_wr),
    .io_addr (io_addr),
    .din     (din),
    .io_dout (io_dout),
    .irq     (irq),
    .ivec    (ivec),
    .iack    (iack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string name, input logic [WIDTH-1:0] val);
    sb_entry_t e;
    e.name = name;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [1:0] addr, input logic [WIDTH-1:0] data);
    io_wr   = 1'b1;
    io_addr = addr;
    din     = data;
    tick();
    io_wr   = 1'b0;
    din     = '0;
  endtask

  task automatic rd(input logic [1:0] addr, output logic [WIDTH-1:0] data);
    io_rd   = 1'b1;
    io_addr = addr;
    #1;
    data    = io_dout;
    io_rd   = 1'b0;
  endtask

  task automatic test_reset();
    sb_entry_t e;
    logic [WIDTH-1:0] obs;
    arstn = 1'b0;
    repeat (3) tick();
    arstn = 1'b1;
    tick();
    expect_val("reset_irqvec", '0);
    e = sb.pop_front(); n_cmp++;
    obs = WIDTH'({irq, ivec});
    if (obs !== e.val) begin n_err++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    for (int a = 0; a < 4; a++) begin
      expect_val($sformatf("reset_reg%0d", a), '0);
      rd(2'(a), obs);
      e = sb.pop_front(); n_cmp++;
      if (obs !== e.val) begin n_err++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    end
    expect_val("idle_dout", '0);
    io_addr = 2'd3;
    #1;
    e = sb.pop_front(); n_cmp++;
    if (io_dout !== e.val) begin n_err++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, io_dout, e.val); end
  endtask

  task automatic test_edge();
    sb_entry_t e;
    logic [WIDTH-1:0] obs;
    wr(2'd1, 18'h0002);
    wr(2'd2, 18'h0002);
    src[1] = 1'b1;
    expect_val("edge_irqvec", 18'h12);
    tick();
    src[1] = 1'b0;
    e = sb.pop_front(); n_cmp++;
    obs = WIDTH'({irq, ivec});
    if (obs !== e.val) begin n_err++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    iack = 1'b1;
    expect_val("edge_ack_irqvec", '0);
    tick();
    iack = 1'b0;
    e = sb.pop_front(); n_cmp++;
    obs = WIDTH'({irq, ivec});
    if (obs !== e.val) begin n_err++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    expect_val("edge_pending_after_ack", '0);
    rd(2'd0, obs);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.val) begin n_err++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
  endtask

  task automatic test_priority();
    sb_entry_t e;
    logic [WIDTH-1:0] obs;
    wr(2'd1, 18'h0005);
    expect_val("prio_first", 18'h13);
    wr(2'd3, 18'h0005);
    e = sb.pop_front(); n_cmp++;
    obs = WIDTH'({irq, ivec});
    if (obs !== e.val) begin n_err++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    iack = 1'b1;
    expect_val("prio_second", 18'h11);
    expect_val("prio_none", '0);
    tick();
    e = sb.pop_front(); n_cmp++;
    obs = WIDTH'({irq, ivec});
    if (obs !== e.val) begin n_err++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    tick();
    iack = 1'b0;
    e = sb.pop_front(); n_cmp++;
    obs = WIDTH'({irq, ivec});
    if (obs !== e.val) begin n_err++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
  endtask

  task automatic test_level();
    sb_entry_t e;
    logic [WIDTH-1:0] obs;
    wr(2'd1, 18'h0001);
    src[0] = 1'b1;
    expect_val("level_first", 18'h11);
    tick();
    e = sb.pop_front(); n_cmp++;
    obs = WIDTH'({irq, ivec});
    if (obs !== e.val) begin n_err++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    iack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      expect_val($sformatf("level_held_%0d", k), 18'h11);
      tick();
      e = sb.pop_front(); n_cmp++;
      obs = WIDTH'({irq, ivec});
      if (obs !== e.val) begin n_err++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    end
    src[0] = 1'b0;
    expect_val("level_dropped", '0);
    tick();
    iack = 1'b0;
    e = sb.pop_front(); n_cmp++;
    obs = WIDTH'({irq, ivec});
    if (obs !== e.val) begin n_err++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
  endtask

  task automatic test_masked();
    sb_entry_t e;
    logic [WIDTH-1:0] obs;
    wr(2'd1, 18'h0000);
    src[4] = 1'b1;
    expect_val("masked_irqvec", '0);
    expect_val("masked_pending", 18'h0010);
    tick();
    src[4] = 1'b0;
    e = sb.pop_front(); n_cmp++;
    obs = WIDTH'({irq, ivec});
    if (obs !== e.val) begin n_err++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    rd(2'd0, obs);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.val) begin n_err++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    expect_val("unmask_irqvec", 18'h15);
    wr(2'd1, 18'h0010);
    e = sb.pop_front(); n_cmp++;
    obs = WIDTH'({irq, ivec});
    if (obs !== e.val) begin n_err++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    expect_val("w1c_irqvec", '0);
    wr(2'd0, 18'h0010);
    e = sb.pop_front(); n_cmp++;
    obs = WIDTH'({irq, ivec});
    if (obs !== e.val) begin n_err++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
  endtask

  task automatic test_set_vs_clear();
    sb_entry_t e;
    logic [WIDTH-1:0] obs;
    wr(2'd2, 18'h0004);
    src[2] = 1'b1;
    expect_val("edge_beats_w1c", 18'h0004);
    wr(2'd0, 18'h0004);
    rd(2'd0, obs);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.val) begin n_err++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    expect_val("held_edge_w1c", '0);
    wr(2'd0, 18'h0004);
    rd(2'd0, obs);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.val) begin n_err++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    src[2] = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    sb_entry_t e;
    logic [WIDTH-1:0] obs;
    wr(2'd1, 18'h0003);
    expect_val("b2b_before", 18'h12);
    wr(2'd3, 18'h0003);
    e = sb.pop_front(); n_cmp++;
    obs = WIDTH'({irq, ivec});
    if (obs !== e.val) begin n_err++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    iack = 1'b1;
    expect_val("b2b_ack_and_w1c", '0);
    wr(2'd0, 18'h0001);
    iack = 1'b0;
    rd(2'd0, obs);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.val) begin n_err++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
  endtask

  task automatic test_force_reset();
    sb_entry_t e;
    logic [WIDTH-1:0] obs;
    wr(2'd1, 18'h7FFF);
    expect_val("force_top_irqvec", 18'h1F);
    expect_val("force_top_read", 18'h1F);
    wr(2'd3, 18'h4000);
    e = sb.pop_front(); n_cmp++;
    obs = WIDTH'({irq, ivec});
    if (obs !== e.val) begin n_err++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    rd(2'd3, obs);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.val) begin n_err++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    expect_val("async_reset_irqvec", '0);
    #1 arstn = 1'b0;
    #1;
    e = sb.pop_front(); n_cmp++;
    obs = WIDTH'({irq, ivec});
    if (obs !== e.val) begin n_err++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    tick();
    arstn = 1'b1;
    tick();
    for (int a = 0; a < 4; a++) begin
      expect_val($sformatf("post_reset_reg%0d", a), '0);
      rd(2'(a), obs);
      e = sb.pop_front(); n_cmp++;
      if (obs !== e.val) begin n_err++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    arstn   = 1'b0;
    src     = '0;
    io_rd   = 1'b0;
    io_wr   = 1'b0;
    io_addr = 2'd0;
    din     = '0;
    iack    = 1'b0;

    test_reset();
    test_edge();
    test_priority();
    test_level();
    test_masked();
    test_set_vs_clear();
    test_back_to_back();
    test_force_reset();

    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
